pkt_tx_ctrl: RTL
================

PKT_TX_CTRL -- requirements
Module: pkt_tx_ctrl

Interface
REQ-001 SHALL have parameter CRC_W, default 16, giving the width of the appended CRC field in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  begin a packet; sampled in IDLE only.
REQ-005 SHALL have port crc_en  input  1  sampled with start; 1 = append CRC after the last byte.
REQ-006 SHALL have port byte_in  input  8  packet byte; the first byte of each packet is the PID.
REQ-007 SHALL have port byte_valid  input  1  byte_in is valid.
REQ-008 SHALL have port byte_last  input  1  qualifies byte_in as the final byte of the packet.
REQ-009 SHALL have port byte_ready  output  1  controller accepts byte_in this cycle.
REQ-010 SHALL have port bit_en  input  1  bit-rate strobe; serial output advances only when high.
REQ-011 SHALL have port bit_out  output  1  serial data, LSB first.
REQ-012 SHALL have port bit_valid  output  1  bit_out carries a packet bit this cycle.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last bit is sent.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, SHIFT, CRC and DONE.
REQ-016 IDLE: on start=1, SHALL latch crc_en, init the CRC register to all ones, set a first-byte flag, and go to LOAD.
REQ-017 LOAD: byte_ready=1; a byte is accepted when byte_valid&byte_ready; then load the 8-bit shifter, latch byte_last, clear the bit count, and go to SHIFT.
REQ-018 LOAD with byte_valid=0: SHALL stall in LOAD with bit_valid=0 and no error.
REQ-019 SHIFT: bit_out = shifter[0] and bit_valid=1; on bit_en=1, shift right one place and increment the bit count.
REQ-020 SHIFT: a byte's first bit SHALL appear on bit_out in the cycle after acceptance.
REQ-021 SHIFT: after the 8th bit_en, SHALL go to LOAD if last=0, else to CRC if crc_en latched, else to DONE.
REQ-022 CRC update per data bit b on bit_en: fb = b ^ crc[15]; crc <= {crc[14:0],1'b0} ^ (fb ? 16'h8005 : 0).
REQ-023 The PID byte SHALL NOT update the CRC; all later bytes SHALL update it.
REQ-024 CRC: bit_out = ~crc[15] and bit_valid=1; on bit_en, crc shifts left one place; after CRC_W bit_en strobes, go to DONE.
REQ-025 DONE: done=1 for exactly one cycle, then go to IDLE; bit_valid=0.
REQ-026 start asserted while busy=1 SHALL be ignored.
REQ-027 byte_ready SHALL be 0 in every state except LOAD; bytes presented outside LOAD are not consumed.
REQ-028 bit_en=0 SHALL freeze the shifter, CRC register, bit count and state in SHIFT/CRC; bit_out stays stable.
REQ-029 byte_last on the PID with crc_en=1 SHALL send PID then CRC_W bits of ~16'hFFFF, i.e. all zeros.

Reset
REQ-030 On rst_b=0 (any state, mid-packet included), SHALL enter IDLE asynchronously with byte_ready=0, bit_out=0, bit_valid=0, busy=0, done=0, shifter=0, CRC=0 and counts=0.
REQ-031 After rst_b deasserts, the first packet SHALL require a fresh start; a partial packet is never resumed.

Structure
REQ-032 Package tx_pkg SHALL hold the state enum tx_state_t and the constants CRC16_POLY=16'h8005 and CRC16_INIT=16'hFFFF.
REQ-033 SHALL instantiate piso_shiftreg #(8) for the byte shifter and counter #(5) for the bit count.
REQ-034 The CRC register and FSM SHALL be written locally; no further sub-modules.

Verification
REQ-035 Directed test, PID-only packet: start, crc_en=0, byte 8'hA5 with last=1, bit_en=1 -> bit_out 1,0,1,0,0,1,0,1, done 1 cycle after the 8th bit.
REQ-036 Directed test, empty data with CRC: PID 8'hC3 last, crc_en=1 -> 8 PID bits, then 16 zeros, then done; total 24 bit_valid cycles.
REQ-037 Directed test, multi-byte packet: PID 8'hC3 + 8'h00,8'h01,8'h02,8'h03 with crc_en=1 -> CRC bits match the bench model of REQ-022/024; byte_ready high exactly 5 times.
REQ-038 Directed test, throttling: bit_en toggled 1-of-4 cycles with byte_valid gaps -> same bit sequence as REQ-037, with bit_valid=0 during LOAD stalls.
REQ-039 Directed test, rst_b pulsed low mid-byte of REQ-037 -> all outputs 0 immediately; start is ignored while busy; after reset a new start yields a clean packet.
REQ-040 Directed test, start held high through DONE -> a second packet begins only from IDLE, with no dropped or duplicated bits.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared types and constants for the packet transmit controller.
// CRC-16 polynomial and seed live here so the model and RTL agree on one source.
package tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CRC   = 3'd3,
    ST_DONE  = 3'd4
  } tx_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/counter.sv
// Up-counter with synchronous clear; clear has priority over increment.
// Wraps silently at 2**W.
module counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/piso_shiftreg.sv
// Parallel-in serial-out shifter, LSB first; ser_out is valid the cycle after load.
// Load wins over shift; holds its contents when neither is asserted.
module piso_shiftreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         shift_en,
  output logic         ser_out
);

  logic [W-1:0] dat_q;
  logic [W-1:0] dat_d;

  always_comb begin
    dat_d = dat_q;
    if (load) begin
      dat_d = load_dat;
    end else if (shift_en) begin
      dat_d = {1'b0, dat_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dat_q <= '0;
    end else begin
      dat_q <= dat_d;
    end
  end

  assign ser_out = dat_q[0];

endmodule

// File: rtl/pkt_tx_ctrl.sv
// Serialises a byte stream LSB first with optional trailing inverted CRC; first bit one cycle after acceptance.
// Byte input stalls (byte_ready low) outside LOAD; bit_en low freezes all shifting state.
module pkt_tx_ctrl
  import tx_pkg::*;
#(
  parameter int CRC_W = 16
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       start,
  input  logic       crc_en,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  input  logic       bit_en,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [CRC_W-1:0] POLY     = CRC_W'(CRC16_POLY);
  localparam logic [4:0]       CRC_LAST = 5'(CRC_W - 1);

  tx_state_t        state_q, state_d;
  logic             crc_en_q, crc_en_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic [CRC_W-1:0] crc_q, crc_d;

  logic       sh_load;
  logic       sh_shift;
  logic       sh_bit;
  logic       cnt_clr;
  logic       cnt_inc;
  logic [4:0] cnt;
  logic       crc_fb;

  piso_shiftreg #(.W(8)) u_shift (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (sh_load),
    .load_dat (byte_in),
    .shift_en (sh_shift),
    .ser_out  (sh_bit)
  );

  // One counter serves both the data bits and the CRC bits.
  counter #(.W(5)) u_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );

  always_comb begin
    state_d    = state_q;
    crc_en_d   = crc_en_q;
    first_d    = first_q;
    last_d     = last_q;
    crc_d      = crc_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    crc_fb     = 1'b0;
    byte_ready = 1'b0;
    bit_out    = 1'b0;
    bit_valid  = 1'b0;
    busy       = (state_q != ST_IDLE);
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          crc_en_d = crc_en;
          crc_d    = '1;
          first_d  = 1'b1;
          state_d  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          sh_load = 1'b1;
          last_d  = byte_last;
          cnt_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        bit_out   = sh_bit;
        bit_valid = 1'b1;
        if (bit_en) begin
          sh_shift = 1'b1;
          cnt_inc  = 1'b1;
          // The PID is transmitted but excluded from the checksum.
          if (!first_q) begin
            crc_fb = sh_bit ^ crc_q[CRC_W-1];
            crc_d  = {crc_q[CRC_W-2:0], 1'b0} ^ (crc_fb ? POLY : '0);
          end
          if (cnt == 5'd7) begin
            first_d = 1'b0;
            cnt_clr = 1'b1;
            if (!last_q) begin
              state_d = ST_LOAD;
            end else if (crc_en_q) begin
              state_d = ST_CRC;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end

      ST_CRC: begin
        bit_out   = ~crc_q[CRC_W-1];
        bit_valid = 1'b1;
        if (bit_en) begin
          crc_d   = {crc_q[CRC_W-2:0], 1'b0};
          cnt_inc = 1'b1;
          if (cnt == CRC_LAST) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= ST_IDLE;
      crc_en_q <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      crc_q    <= '0;
    end else begin
      state_q  <= state_d;
      crc_en_q <= crc_en_d;
      first_q  <= first_d;
      last_q   <= last_d;
      crc_q    <= crc_d;
    end
  end

endmodule
